// File: rtl/frag_multi_wr_buffer_if.sv
// Bundle of write/read/status signals for frag_multi_wr_buffer.
// The master drives requests; the slave (the buffer) drives data_out and status.
interface frag_multi_wr_buffer_if #(
   parameter int ENTRY_W  = 32,
   parameter int DEPTH    = 16,
   parameter int WR_LANES = 8
);
   localparam int NW    = $clog2(WR_LANES + 1);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                         flush;
   logic                         wr_en;
   logic [NW-1:0]                no_loc_wr;
   logic [WR_LANES*ENTRY_W-1:0]  data_in;
   logic                         rd_en;
   logic [ENTRY_W-1:0]           data_out;
   logic                         empty_buffer;
   logic [CNT_W-1:0]             empty_loc;
   logic                         almost_full;
   logic                         wr_reject;
   logic                         rd_underflow;

   modport master (
      output flush, wr_en, no_loc_wr, data_in, rd_en,
      input  data_out, empty_buffer, empty_loc, almost_full, wr_reject, rd_underflow
   );

   modport slave (
      input  flush, wr_en, no_loc_wr, data_in, rd_en,
      output data_out, empty_buffer, empty_loc, almost_full, wr_reject, rd_underflow
   );
endinterface

// File: rtl/frag_multi_wr_buffer.sv
// Circular buffer accepting 1..WR_LANES locations per cycle and popping one
// location per cycle, with show-ahead head data and drop/underflow pulses.
module frag_multi_wr_buffer #(
   parameter int ENTRY_W   = 32,
   parameter int DEPTH     = 16,
   parameter int WR_LANES  = 8,
   parameter int AF_THRESH = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   frag_multi_wr_buffer_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int NW    = $clog2(WR_LANES + 1);

   logic [ENTRY_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             wr_reject_reg, wr_reject_next;
   logic             rd_underflow_reg, rd_underflow_next;

   logic [CNT_W-1:0] n_ext;
   logic [CNT_W-1:0] free_loc;
   logic             is_empty;
   logic             wr_legal;
   logic             wr_ok;
   logic             rd_ok;

   logic [PTR_W-1:0]   lane_addr [WR_LANES];
   logic [ENTRY_W-1:0] lane_data [WR_LANES];
   logic               lane_we   [WR_LANES];

   assign is_empty = (count_reg == '0);
   assign free_loc = CNT_W'(DEPTH) - count_reg;
   assign n_ext    = CNT_W'(bus.no_loc_wr);

   // Space is judged on the registered count, so a same-cycle pop never makes room.
   assign wr_legal = bus.wr_en && (bus.no_loc_wr != '0) &&
                     (bus.no_loc_wr <= NW'(WR_LANES)) && (n_ext <= free_loc);
   assign wr_ok    = wr_legal && !bus.flush;
   assign rd_ok    = bus.rd_en && !is_empty && !bus.flush;

   generate
      for (genvar gi = 0; gi < WR_LANES; gi++) begin : g_lane
         assign lane_addr[gi] = wr_ptr_reg + PTR_W'(gi);
         assign lane_data[gi] = bus.data_in[gi*ENTRY_W +: ENTRY_W];
         assign lane_we[gi]   = rst_n && wr_ok && (NW'(gi) < bus.no_loc_wr);
      end
   endgenerate

   always_comb begin
      wr_ptr_next       = wr_ptr_reg;
      rd_ptr_next       = rd_ptr_reg;
      count_next        = count_reg;
      wr_reject_next    = 1'b0;
      rd_underflow_next = 1'b0;
      if (bus.flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(bus.no_loc_wr);
         end
         if (rd_ok) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         count_next        = count_reg + (wr_ok ? n_ext : '0) - (rd_ok ? CNT_W'(1) : '0);
         wr_reject_next    = bus.wr_en && !wr_legal;
         rd_underflow_next = bus.rd_en && is_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         wr_reject_reg    <= 1'b0;
         rd_underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg       <= wr_ptr_next;
         rd_ptr_reg       <= rd_ptr_next;
         count_reg        <= count_next;
         wr_reject_reg    <= wr_reject_next;
         rd_underflow_reg <= rd_underflow_next;
      end
   end

   // Storage is never reset; lane addresses wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WR_LANES; i++) begin
         if (lane_we[i]) begin
            mem[lane_addr[i]] <= lane_data[i];
         end
      end
   end

   assign bus.data_out     = is_empty ? '0 : mem[rd_ptr_reg];
   assign bus.empty_buffer = is_empty;
   assign bus.empty_loc    = free_loc;
   assign bus.almost_full  = (count_reg >= CNT_W'(AF_THRESH));
   assign bus.wr_reject    = wr_reject_reg;
   assign bus.rd_underflow = rd_underflow_reg;
endmodule

// File: tb/tb_frag_multi_wr_buffer.sv
// Directed bench for frag_multi_wr_buffer: fill, drop, wrap, full, underflow,
// flush and reset-during-write scenarios with hand-computed expectations.
module tb_frag_multi_wr_buffer;
   localparam int ENTRY_W = 32;
   localparam int DEPTH   = 16;
   localparam int LANES   = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   frag_multi_wr_buffer_if #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .WR_LANES(LANES)) bus ();

   frag_multi_wr_buffer #(
      .ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .WR_LANES(LANES), .AF_THRESH(12)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int n, input logic [31:0] base);
      bus.wr_en     = 1'b1;
      bus.no_loc_wr = 4'(n);
      bus.data_in   = '0;
      for (int k = 0; k < LANES; k++) bus.data_in[k*ENTRY_W +: ENTRY_W] = base + 32'(k);
   endtask

   task automatic idle();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.flush = 1'b0;
      bus.no_loc_wr = '0;
   endtask

   task automatic show(input int n, input logic [31:0] base);
      $display("txn wr n=%0d base=%0h empty_loc=%0d", n, base, bus.empty_loc);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.data_in = '0;
      idle();
      step();
      step();
      chk("rst_empty", 32'(bus.empty_buffer), 32'd1);
      chk("rst_empty_loc", 32'(bus.empty_loc), 32'd16);
      chk("rst_af", 32'(bus.almost_full), 32'd0);
      chk("rst_data", bus.data_out, 32'd0);
      chk("rst_rej", 32'(bus.wr_reject), 32'd0);
      chk("rst_unf", 32'(bus.rd_underflow), 32'd0);
      rst_n = 1'b1;

      // Write three lanes, then pop them back.
      set_wr(3, 32'h1000);
      step();
      idle();
      show(3, 32'h1000);
      chk("w3_empty_loc", 32'(bus.empty_loc), 32'd13);
      chk("w3_head", bus.data_out, 32'h1000);
      for (int i = 0; i < 3; i++) begin
         chk("w3_pop", bus.data_out, 32'h1000 + 32'(i));
         bus.rd_en = 1'b1;
         step();
         $display("txn rd data=%0h", bus.data_out);
      end
      idle();
      chk("w3_drained", 32'(bus.empty_buffer), 32'd1);
      chk("w3_drained_data", bus.data_out, 32'd0);

      // Read while empty.
      bus.rd_en = 1'b1;
      step();
      idle();
      $display("txn rd on empty");
      chk("unf_pulse", 32'(bus.rd_underflow), 32'd1);
      chk("unf_empty_loc", 32'(bus.empty_loc), 32'd16);
      step();
      chk("unf_clear", 32'(bus.rd_underflow), 32'd0);

      // Fill to 12 (pointers start at 3).
      set_wr(8, 32'h2000);
      step();
      show(8, 32'h2000);
      chk("f8_empty_loc", 32'(bus.empty_loc), 32'd8);
      chk("f8_af", 32'(bus.almost_full), 32'd0);
      set_wr(4, 32'h2100);
      step();
      show(4, 32'h2100);
      chk("f12_empty_loc", 32'(bus.empty_loc), 32'd4);
      chk("f12_af", 32'(bus.almost_full), 32'd1);
      chk("f12_head", bus.data_out, 32'h2000);
      set_wr(5, 32'h2200);
      step();
      idle();
      show(5, 32'h2200);
      chk("drop_pulse", 32'(bus.wr_reject), 32'd1);
      chk("drop_empty_loc", 32'(bus.empty_loc), 32'd4);
      step();
      chk("drop_clear", 32'(bus.wr_reject), 32'd0);

      // Fill to full across the 15->0 boundary.
      set_wr(4, 32'h3000);
      step();
      show(4, 32'h3000);
      chk("full_empty_loc", 32'(bus.empty_loc), 32'd0);
      set_wr(1, 32'h3100);
      bus.rd_en = 1'b1;
      step();
      idle();
      show(1, 32'h3100);
      chk("full_rw_rej", 32'(bus.wr_reject), 32'd1);
      chk("full_rw_empty_loc", 32'(bus.empty_loc), 32'd1);
      for (int k = 1; k < 8; k++) exp_q.push_back(32'h2000 + 32'(k));
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h2100 + 32'(k));
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h3000 + 32'(k));
      foreach (exp_q[i]) begin
         chk("drain", bus.data_out, exp_q[i]);
         bus.rd_en = 1'b1;
         step();
      end
      idle();
      $display("txn drained %0d entries", exp_q.size());
      chk("drain_empty", 32'(bus.empty_buffer), 32'd1);

      // Flush overrides a concurrent write and read.
      set_wr(7, 32'h4000);
      step();
      show(7, 32'h4000);
      chk("fl_pre_empty_loc", 32'(bus.empty_loc), 32'd9);
      set_wr(2, 32'h4100);
      bus.rd_en = 1'b1;
      bus.flush = 1'b1;
      step();
      idle();
      $display("txn flush");
      chk("fl_empty_loc", 32'(bus.empty_loc), 32'd16);
      chk("fl_data", bus.data_out, 32'd0);
      chk("fl_rej", 32'(bus.wr_reject), 32'd0);
      chk("fl_unf", 32'(bus.rd_underflow), 32'd0);

      // Reset during a write at count 9.
      set_wr(8, 32'h5000);
      step();
      set_wr(1, 32'h5100);
      step();
      show(9, 32'h5000);
      chk("r9_empty_loc", 32'(bus.empty_loc), 32'd7);
      set_wr(3, 32'h5200);
      rst_n = 1'b0;
      step();
      idle();
      rst_n = 1'b1;
      $display("txn reset during write");
      chk("rw_empty_loc", 32'(bus.empty_loc), 32'd16);
      chk("rw_rej", 32'(bus.wr_reject), 32'd0);
      chk("rw_empty", 32'(bus.empty_buffer), 32'd1);

      // Zero-length write is dropped; then a fresh write is visible.
      set_wr(0, 32'h6000);
      step();
      idle();
      show(0, 32'h6000);
      chk("z_rej", 32'(bus.wr_reject), 32'd1);
      chk("z_empty_loc", 32'(bus.empty_loc), 32'd16);
      set_wr(2, 32'h7000);
      step();
      idle();
      show(2, 32'h7000);
      chk("post_head", bus.data_out, 32'h7000);
      chk("post_empty_loc", 32'(bus.empty_loc), 32'd14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
